// File: rtl/reg_bank_resp.sv
// rtl/reg_bank_resp.sv - register bank responder: flop storage, 1-cycle read response, address error tracking
module reg_bank_resp #(
  parameter int NUM_REGS  = 14,
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 16,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 write_en,
  input  logic                 read_en,
  input  logic [ADDR_W-1:0]    addr,
  input  logic [DATA_W-1:0]    data_in,
  output logic [DATA_W-1:0]    data_out,
  output logic                 rd_valid,
  output logic                 addr_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RESP = 1'b1
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   w_rd_valid;
  logic [DATA_W-1:0]      r_regs [NUM_REGS];
  logic [DATA_W-1:0]      r_data_out;
  logic                   r_addr_err;
  logic [ERR_CNT_W-1:0]   r_err_count;
  logic                   w_addr_ok;
  logic                   w_err;
  logic [DATA_W-1:0]      w_rd_data;

  assign w_addr_ok = ({1'b0, addr} < (ADDR_W+1)'(NUM_REGS));
  assign w_err     = (write_en | read_en) & ~w_addr_ok;

  // Mux the stored word; an invalid address matches no entry and yields zero.
  always_comb begin
    w_rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (addr == ADDR_W'(i)) begin
        w_rd_data = r_regs[i];
      end
    end
  end

  // The read mux samples pre-edge contents, so a same-cycle write is not seen.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (write_en) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (addr == ADDR_W'(i)) begin
          r_regs[i] <= data_in;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_data_out  <= '0;
      r_addr_err  <= 1'b0;
      r_err_count <= '0;
    end else begin
      if (read_en) begin
        r_data_out <= w_rd_data;
      end
      r_addr_err <= w_err;
      if (w_err && (r_err_count != {ERR_CNT_W{1'b1}})) begin
        r_err_count <= r_err_count + ERR_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rd_valid  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (read_en) begin
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        w_rd_valid = 1'b1;
        if (!read_en) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign data_out  = r_data_out;
  assign rd_valid  = w_rd_valid;
  assign addr_err  = r_addr_err;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_reg_bank_resp.sv
// tb/tb_reg_bank_resp.sv - directed plus randomized bench for reg_bank_resp against a behavioural model
module tb_reg_bank_resp;
  localparam int NUM_REGS  = 14;
  localparam int ADDR_W    = 4;
  localparam int DATA_W    = 16;
  localparam int ERR_CNT_W = 8;
  localparam int CNT_MAX   = (1 << ERR_CNT_W) - 1;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 write_en = 1'b0;
  logic                 read_en = 1'b0;
  logic [ADDR_W-1:0]    addr = '0;
  logic [DATA_W-1:0]    data_in = '0;
  logic [DATA_W-1:0]    data_out;
  logic                 rd_valid;
  logic                 addr_err;
  logic [ERR_CNT_W-1:0] err_count;

  int tests = 0;
  int fails = 0;

  int m_regs [NUM_REGS];
  int m_do;
  int m_v;
  int m_err;
  int m_cnt;

  reg_bank_resp #(
    .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ERR_CNT_W(ERR_CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .write_en(write_en), .read_en(read_en), .addr(addr),
    .data_in(data_in), .data_out(data_out), .rd_valid(rd_valid),
    .addr_err(addr_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    assert (act === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // One clock: drive inputs, advance the model by the behavioural rules, compare all outputs.
  task automatic step(input logic r, input logic we, input logic re, input int a, input int d);
    bit valid;
    @(negedge clk);
    rst      = r;
    write_en = we;
    read_en  = re;
    addr     = ADDR_W'(a);
    data_in  = DATA_W'(d);
    if (!r) begin
      for (int i = 0; i < NUM_REGS; i++) m_regs[i] = 0;
      m_do = 0; m_v = 0; m_err = 0; m_cnt = 0;
    end else begin
      valid = (a < NUM_REGS);
      m_v   = re ? 1 : 0;
      m_err = ((we || re) && !valid) ? 1 : 0;
      if (re) m_do = valid ? m_regs[a] : 0;
      if (m_err == 1 && m_cnt < CNT_MAX) m_cnt++;
      if (we && valid) m_regs[a] = d & 16'hFFFF;
    end
    @(posedge clk);
    #1;
    check("data_out", 32'(data_out), 32'(m_do));
    check("rd_valid", 32'(rd_valid), 32'(m_v));
    check("addr_err", 32'(addr_err), 32'(m_err));
    check("err_count", 32'(err_count), 32'(m_cnt));
  endtask

  initial begin
    step(0, 0, 0, 0, 0);
    step(0, 1, 1, 3, 16'h5A5A);
    check("reset_data_out", 32'(data_out), 32'h0);
    check("reset_err_count", 32'(err_count), 32'h0);

    for (int i = 0; i < NUM_REGS; i++) begin
      step(1, 0, 1, i, 0);
      check("post_reset_read", 32'(data_out), 32'h0);
    end
    step(1, 0, 0, 0, 0);

    for (int i = 0; i < NUM_REGS; i++) step(1, 1, 0, i, 16'h1234 + i);
    for (int i = 0; i < NUM_REGS; i++) begin
      step(1, 0, 1, i, 0);
      check("readback_ramp", 32'(data_out), 32'(16'h1234 + i));
    end
    step(1, 1, 0, 1, 16'hFFFF);
    step(1, 1, 0, 2, 16'h8000);
    step(1, 1, 0, 3, 16'hAAAA);
    step(1, 1, 0, 4, 16'h5555);
    step(1, 0, 1, 1, 0); check("pattern_ffff", 32'(data_out), 32'hFFFF);
    step(1, 0, 1, 2, 0); check("pattern_8000", 32'(data_out), 32'h8000);
    step(1, 0, 1, 3, 0); check("pattern_aaaa", 32'(data_out), 32'hAAAA);
    step(1, 0, 1, 4, 0); check("pattern_5555", 32'(data_out), 32'h5555);

    step(1, 1, 0, 5, 16'hBEEF);
    step(1, 1, 1, 5, 16'hCAFE);
    check("rbw_old_value", 32'(data_out), 32'hBEEF);
    step(1, 0, 1, 5, 0);
    check("rbw_new_value", 32'(data_out), 32'hCAFE);

    step(1, 1, 0, 14, 16'hDEAD);
    check("inv_wr_err", 32'(addr_err), 32'h1);
    step(1, 0, 1, 15, 0);
    check("inv_rd_data", 32'(data_out), 32'h0);
    check("inv_rd_valid", 32'(rd_valid), 32'h1);
    check("inv_err_count2", 32'(err_count), 32'h2);
    for (int i = 0; i < NUM_REGS; i++) step(1, 0, 1, i, 0);
    for (int i = 0; i < 300; i++) begin
      int sel;
      sel = $urandom_range(2, 0);
      step(1, sel != 1, sel != 0, $urandom_range(15, 14), $urandom);
    end
    check("err_saturate", 32'(err_count), 32'(CNT_MAX));

    step(1, 0, 1, 3, 0);
    step(1, 0, 1, 3, 0);
    step(1, 0, 1, 3, 0);
    check("b2b_valid", 32'(rd_valid), 32'h1);
    step(1, 0, 0, 3, 0);
    check("b2b_drop", 32'(rd_valid), 32'h0);
    check("b2b_hold", 32'(data_out), 32'hAAAA);

    step(1, 1, 0, 7, 16'h00FF);
    step(1, 0, 1, 7, 0);
    check("pre_reset_read", 32'(data_out), 32'h00FF);
    step(0, 0, 1, 7, 0);
    check("reset_cancels_valid", 32'(rd_valid), 32'h0);
    check("reset_clears_count", 32'(err_count), 32'h0);
    for (int i = 0; i < NUM_REGS; i++) step(1, 0, 1, i, 0);

    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(63, 0) != 0), $urandom_range(1, 0) == 1,
           $urandom_range(1, 0) == 1, $urandom_range(15, 0), $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
